code_loader: RTL

- Byte-stream boot loader that fills the processor's 512x16 code memory, then releases the core.
- It is the writer side of the datapath's code-memory load port: it drives code_w_en, the code address and the code word.
- After a length-framed, checksummed image is loaded, it asserts run.
- The byte source is a valid/ready stream, typically a UART receiver.

---
 rtl/code_loader_pkg.sv | 42 ++++
 rtl/code_loader_reg.sv | 21 ++
 rtl/code_loader.sv | 145 ++++++++++++++
 3 files changed

// File: rtl/code_loader_pkg.sv
// Shared definitions for the byte-stream code-memory boot loader.
package code_loader_pkg;

    localparam int LOADER_ADDR_W    = 9;
    localparam int LOADER_WORD_W    = 16;
    localparam int LOADER_MAX_WORDS = 512;
    localparam int LOADER_CNT_W     = 10;

    // Loader FSM states, 4-bit encoded.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LEN_HI  = 4'd1,
        ST_LEN_LO  = 4'd2,
        ST_DATA_HI = 4'd3,
        ST_DATA_LO = 4'd4,
        ST_WRITE   = 4'd5,
        ST_CHECK   = 4'd6,
        ST_DONE    = 4'd7,
        ST_ERR     = 4'd8
    } state_t;

    // Order of fields on the wire: length (high byte first), LEN words
    // sent as (HI, LO) byte pairs, then the checksum byte.
    typedef enum logic [1:0] {
        FLD_LEN_HI = 2'd0,
        FLD_LEN_LO = 2'd1,
        FLD_DATA   = 2'd2,
        FLD_CHK    = 2'd3
    } frame_field_t;

    // States in which a stream byte may be accepted.
    function automatic logic takes_byte(input state_t s);
        return (s == ST_LEN_HI) || (s == ST_LEN_LO) || (s == ST_DATA_HI) ||
               (s == ST_DATA_LO) || (s == ST_CHECK);
    endfunction

    // States that make up an active load.
    function automatic logic is_busy(input state_t s);
        return takes_byte(s) || (s == ST_WRITE);
    endfunction

endpackage

// File: rtl/code_loader_reg.sv
// Generic load-enabled holding register with asynchronous clear.
module code_loader_reg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_en,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    // Capture i_d when enabled; clear on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_q <= '0;
        end else if (i_en) begin
            o_q <= i_d;
        end
    end

endmodule

// File: rtl/code_loader.sv
// Boot loader: receives a length-framed, checksummed image over a byte
// stream, writes it into code memory and then releases the core via run.
module code_loader
    import code_loader_pkg::*;
#(
    parameter int ADDR_W    = LOADER_ADDR_W,
    parameter int WORD_W    = LOADER_WORD_W,
    parameter int MAX_WORDS = LOADER_MAX_WORDS
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              rx_data,
    input  logic                    rx_valid,
    output logic                    rx_ready,
    output logic                    code_w_en,
    output logic [ADDR_W-1:0]       code_addr,
    output logic [WORD_W-1:0]       code_data,
    output logic                    run,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [LOADER_CNT_W-1:0] words_loaded
);

    state_t                  r_state;
    state_t                  w_next;
    logic [ADDR_W-1:0]       r_addr;
    logic [LOADER_CNT_W-1:0] r_words;
    logic [7:0]              r_sum;

    logic                    w_hs;
    logic                    w_clear;
    logic [7:0]              w_len_hi;
    logic [15:0]             w_len_full;
    logic [LOADER_CNT_W-1:0] w_len;
    logic                    w_len_bad;
    logic [LOADER_CNT_W-1:0] w_words_inc;
    logic                    w_last;
    logic [7:0]              w_sum_chk;
    logic [7:0]              w_hi;
    logic [7:0]              w_lo;

    assign w_hs        = rx_valid && rx_ready;
    assign w_clear     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE) ||
                                   (r_state == ST_ERR));
    assign w_len_full  = {w_len_hi, rx_data};
    assign w_len_bad   = (w_len_full == 16'd0) || (32'(w_len_full) > MAX_WORDS);
    assign w_words_inc = r_words + 1'b1;
    assign w_last      = (w_words_inc == w_len);
    assign w_sum_chk   = r_sum + rx_data;

    // Length is only ever consumed after a successful LEN_LO check, so the
    // low 10 bits hold the whole accepted value.
    code_loader_reg #(.W(8)) u_len_hi (
        .clk (clk),
        .rst (rst),
        .i_en(w_hs && (r_state == ST_LEN_HI)),
        .i_d (rx_data),
        .o_q (w_len_hi)
    );

    code_loader_reg #(.W(LOADER_CNT_W)) u_len (
        .clk (clk),
        .rst (rst),
        .i_en(w_hs && (r_state == ST_LEN_LO)),
        .i_d (w_len_full[LOADER_CNT_W-1:0]),
        .o_q (w_len)
    );

    code_loader_reg #(.W(8)) u_data_hi (
        .clk (clk),
        .rst (rst),
        .i_en(w_hs && (r_state == ST_DATA_HI)),
        .i_d (rx_data),
        .o_q (w_hi)
    );

    code_loader_reg #(.W(8)) u_data_lo (
        .clk (clk),
        .rst (rst),
        .i_en(w_hs && (r_state == ST_DATA_LO)),
        .i_d (rx_data),
        .o_q (w_lo)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; start is only honoured outside an active load.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERR: if (start) w_next = ST_LEN_HI;
            ST_LEN_HI:  if (w_hs) w_next = ST_LEN_LO;
            ST_LEN_LO:  if (w_hs) w_next = w_len_bad ? ST_ERR : ST_DATA_HI;
            ST_DATA_HI: if (w_hs) w_next = ST_DATA_LO;
            ST_DATA_LO: if (w_hs) w_next = ST_WRITE;
            ST_WRITE:   w_next = w_last ? ST_CHECK : ST_DATA_HI;
            ST_CHECK:   if (w_hs) w_next = (w_sum_chk == 8'd0) ? ST_DONE : ST_ERR;
            default:    w_next = ST_IDLE;
        endcase
    end

    // Address, word count and running checksum. The address holds at LEN-1
    // after the final write so a full image never wraps back to 0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr  <= '0;
            r_words <= '0;
            r_sum   <= '0;
        end else if (w_clear) begin
            r_addr  <= '0;
            r_words <= '0;
            r_sum   <= '0;
        end else begin
            if (w_hs && ((r_state == ST_DATA_HI) || (r_state == ST_DATA_LO))) begin
                r_sum <= w_sum_chk;
            end
            if (r_state == ST_WRITE) begin
                r_words <= w_words_inc;
                if (!w_last) begin
                    r_addr <= r_addr + 1'b1;
                end
            end
        end
    end

    assign rx_ready     = takes_byte(r_state);
    assign code_w_en    = (r_state == ST_WRITE);
    assign code_addr    = r_addr;
    assign code_data    = {w_hi, w_lo};
    assign run          = (r_state == ST_DONE);
    assign done         = (r_state == ST_DONE);
    assign error        = (r_state == ST_ERR);
    assign busy         = is_busy(r_state);
    assign words_loaded = r_words;

endmodule
